// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_arbiter_pkg;

    // Grant state encoding, fixed so that grant bits map directly from state.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_GRANT0 = GRANT0,
        ST_GRANT1 = GRANT1
    } arb_state_t;

    // Width of the per-grant transfer counter (MAX_BURST tops out at 255).
    localparam int BURST_CNT_W = 8;

    // One-hot owner derived from the state; 00 while idle.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        return {s == ST_GRANT1, s == ST_GRANT0};
    endfunction

endpackage

// File: rtl/mux_2x1_nbit.sv
// n-bit 2:1 select between the two requester words.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mux_2x1_nbit #(
    parameter int n = 3
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         s,
    output logic [n-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_arbiter_2x1.sv
// Round-robin burst arbiter: two valid/ready requesters share one registered n-bit output.
// Latency: grant one edge after valid is seen in IDLE, first word lands in f one edge later.
// Backpressure: ready of the owner follows (!f_valid | f_ready); ARB_BURST_LIMIT_EN caps bursts.
module mux_arbiter_2x1
    import mux_arbiter_pkg::*;
#(
    parameter int n         = 3,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid0,
    input  logic         valid1,
    input  logic [n-1:0] w0,
    input  logic [n-1:0] w1,
    output logic         ready0,
    output logic         ready1,
    output logic [1:0]   grant,
    output logic [n-1:0] f,
    output logic         f_valid,
    output logic         f_src,
    input  logic         f_ready
);

    // A burst limit outside 1..255 cannot be represented by the counter.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("mux_arbiter_2x1: MAX_BURST must be in 1..255");
    end

    arb_state_t   state;
    arb_state_t   state_nxt;
    logic         prio;
    logic         prio_nxt;
    logic [n-1:0] mux_y;
    logic         out_free;
    logic         own_vld;
    logic         oth_vld;
    arb_state_t   oth_state;
    logic         xfer;

    assign grant    = grant_of(state);
    assign out_free = !f_valid || f_ready;
    assign ready0   = grant[0] && out_free;
    assign ready1   = grant[1] && out_free;
    assign xfer     = (valid0 && ready0) || (valid1 && ready1);

    // Owner/other view of the request lines, only meaningful in a GRANT state.
    assign own_vld   = grant[1] ? valid1 : valid0;
    assign oth_vld   = grant[1] ? valid0 : valid1;
    assign oth_state = grant[1] ? ST_GRANT0 : ST_GRANT1;

    mux_2x1_nbit #(
        .n (n)
    ) u_sel (
        .a (w0),
        .b (w1),
        .s (grant[1]),
        .y (mux_y)
    );

`ifdef ARB_BURST_LIMIT_EN
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] burst_cnt_nxt;
    logic                   burst_done;

    // The transfer in flight is the last one allowed in this grant.
    assign burst_done = xfer && (burst_cnt == BURST_CNT_W'(MAX_BURST - 1));
`endif

    // Next grant and priority: tie-break on prio from IDLE, hand over on release.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
`ifdef ARB_BURST_LIMIT_EN
        burst_cnt_nxt = burst_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (valid0 && valid1) begin
                    state_nxt = prio ? ST_GRANT1 : ST_GRANT0;
                end else if (valid0) begin
                    state_nxt = ST_GRANT0;
                end else if (valid1) begin
                    state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!own_vld) begin
                    // Release: go straight to the waiting requester, no IDLE bubble.
                    state_nxt = oth_vld ? oth_state : ST_IDLE;
                    prio_nxt  = grant[0];
                end
`ifdef ARB_BURST_LIMIT_EN
                else if (xfer) begin
                    if (burst_done) begin
                        burst_cnt_nxt = '0;
                        if (oth_vld) begin
                            state_nxt = oth_state;
                            prio_nxt  = grant[0];
                        end
                    end else begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef ARB_BURST_LIMIT_EN
        if (state_nxt != state) begin
            burst_cnt_nxt = '0;
        end
`endif
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    // Transfers taken in the current grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
        end
    end
`endif

    // Single output stage: load on transfer (even while being consumed), else drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f       <= '0;
            f_valid <= 1'b0;
            f_src   <= 1'b0;
        end else if (xfer) begin
            f       <= mux_y;
            f_valid <= 1'b1;
            f_src   <= grant[1];
        end else if (f_valid && f_ready) begin
            f_valid <= 1'b0;
        end
    end

endmodule
